// File: rtl/dist_display_pkg.sv
// rtl/dist_display_pkg.sv - shared FSM encodings, digit count and seven-segment constants
package dist_display_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam int NUM_DIGITS = 5;

    // Active-low segments ordered {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        case (nib)
            4'd0:    seg_decode = SEG_0;
            4'd1:    seg_decode = SEG_1;
            4'd2:    seg_decode = SEG_2;
            4'd3:    seg_decode = SEG_3;
            4'd4:    seg_decode = SEG_4;
            4'd5:    seg_decode = SEG_5;
            4'd6:    seg_decode = SEG_6;
            4'd7:    seg_decode = SEG_7;
            4'd8:    seg_decode = SEG_8;
            4'd9:    seg_decode = SEG_9;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - change-triggered sequential 16-bit binary to 5-digit BCD converter
module bin2bcd_seq
    import dist_display_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] d,
    output logic [19:0] bcd,
    output logic        valid,
    output logic        busy
);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] d_last;
    logic [15:0] sh;
    logic [19:0] acc;
    logic [19:0] acc_adj;
    logic [3:0]  cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (d != d_last) state_nxt = S_SHIFT;
            S_SHIFT: if (cnt == 4'd15) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Add-3 on every nibble >= 5 before the shift; nibble wrap cannot occur
    always_comb begin
        acc_adj = acc;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_last <= '0;
            sh     <= '0;
            acc    <= '0;
            cnt    <= '0;
            bcd    <= '0;
            valid  <= 1'b0;
        end else begin
            valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (d != d_last) begin
                        d_last <= d;
                        sh     <= d;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                S_SHIFT: begin
                    acc <= {acc_adj[18:0], sh[15]};
                    sh  <= {sh[14:0], 1'b0};
                    cnt <= cnt + 4'd1;
                end
                S_DONE: begin
                    bcd   <= acc;
                    valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != S_IDLE);

endmodule

// File: rtl/dist_display.sv
// rtl/dist_display.sv - rangefinder distance to multiplexed 5-digit seven-segment display; DIST_DISPLAY_BLANK_EN enables leading-zero blanking
module dist_display
    import dist_display_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [15:0] D,
    output logic [19:0] Bcd,
    output logic        Valid,
    output logic        Busy,
    output logic [4:0]  An,
    output logic [6:0]  Seg
);

    localparam logic [15:0] PRE_MAX = 16'(SCAN_DIV - 1);
    localparam logic [2:0]  IDX_MAX = 3'(NUM_DIGITS - 1);

    logic [15:0] pre;
    logic [2:0]  idx;
    logic [3:0]  digit;
    logic [6:0]  seg_nxt;

    bin2bcd_seq u_conv (
        .clk   (Clk),
        .rst   (Rst),
        .d     (D),
        .bcd   (Bcd),
        .valid (Valid),
        .busy  (Busy)
    );

    always_comb begin
        digit = Bcd[3:0];
        case (idx)
            3'd1:    digit = Bcd[7:4];
            3'd2:    digit = Bcd[11:8];
            3'd3:    digit = Bcd[15:12];
            3'd4:    digit = Bcd[19:16];
            default: digit = Bcd[3:0];
        endcase
    end

`ifdef DIST_DISPLAY_BLANK_EN
    logic [4:0] lead_zero;

    // A digit is blanked only if it and every higher digit are zero; ones digit always shows
    always_comb begin
        lead_zero[4] = (Bcd[19:16] == 4'd0);
        lead_zero[3] = lead_zero[4] && (Bcd[15:12] == 4'd0);
        lead_zero[2] = lead_zero[3] && (Bcd[11:8] == 4'd0);
        lead_zero[1] = lead_zero[2] && (Bcd[7:4] == 4'd0);
        lead_zero[0] = 1'b0;
    end

    always_comb begin
        seg_nxt = seg_decode(digit);
        if (lead_zero[idx]) seg_nxt = SEG_BLANK;
    end
`else
    always_comb begin
        seg_nxt = seg_decode(digit);
    end
`endif

    always_ff @(posedge Clk) begin
        if (Rst) begin
            pre <= '0;
            idx <= '0;
            An  <= 5'b11110;
            Seg <= SEG_0;
        end else begin
            if (pre == PRE_MAX) begin
                pre <= '0;
                idx <= (idx == IDX_MAX) ? 3'd0 : idx + 3'd1;
            end else begin
                pre <= pre + 16'd1;
            end
            An  <= ~(5'b00001 << idx);
            Seg <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_dist_display.sv
// tb/tb_dist_display.sv - directed self-checking bench for dist_display with SCAN_DIV=4
module tb_dist_display;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [15:0] D;
    logic [19:0] Bcd;
    logic        Valid;
    logic        Busy;
    logic [4:0]  An;
    logic [6:0]  Seg;

    int checks = 0;
    int errors = 0;

    logic [4:0] exp_an [5] = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111};
    // Digits of 01234 from ones upward: 4,3,2,1,0
    logic [6:0] exp_seg [5] = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000};

    dist_display #(.SCAN_DIV(4)) dut (
        .Clk   (Clk),
        .Rst   (Rst),
        .D     (D),
        .Bcd   (Bcd),
        .Valid (Valid),
        .Busy  (Busy),
        .An    (An),
        .Seg   (Seg)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic watch(input int ncyc, output int first_v, output int nvalid,
                         output int nbusy, output logic [19:0] vbcd);
        first_v = -1;
        nvalid  = 0;
        nbusy   = 0;
        vbcd    = '0;
        for (int n = 1; n <= ncyc; n++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (Busy) nbusy++;
            if (Valid) begin
                nvalid++;
                if (first_v < 0) begin
                    first_v = n;
                    vbcd    = Bcd;
                end
            end
        end
    endtask

    task automatic convert(input logic [15:0] val, input logic [19:0] exp, input string tag);
        int fv, nv, nb;
        logic [19:0] vb;
        @(posedge Clk);
        #1 D = val;
        watch(40, fv, nv, nb, vb);
        check({tag, "_valid_at"}, fv, 18);
        check({tag, "_valid_cnt"}, nv, 1);
        check({tag, "_busy_cycles"}, nb, 17);
        check({tag, "_bcd_at_valid"}, vb, exp);
        check({tag, "_bcd_hold"}, Bcd, exp);
    endtask

    initial begin
        int fv, nv, nb;
        logic [19:0] vb;
        int v1, v2;
        logic [19:0] b1, b2;
        logic busy18, busy19;
        logic [4:0] prev_an;
        bit found;

        Rst = 1'b1;
        D   = 16'd0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_busy", Busy, 0);
        check("rst_valid", Valid, 0);
        check("rst_bcd", Bcd, 20'h00000);
        check("rst_an", An, 5'b11110);
        check("rst_seg", Seg, 7'b1000000);

        @(posedge Clk);
        #1 Rst = 1'b0;
        watch(20, fv, nv, nb, vb);
        check("idle_busy", nb, 0);
        check("idle_valid", nv, 0);
        check("idle_bcd", Bcd, 20'h00000);

        convert(16'd1234, 20'h01234, "c1234");
        convert(16'd65535, 20'h65535, "c65535");
        convert(16'd10000, 20'h10000, "c10000");

        // Second value arrives mid-conversion: converted right after the first finishes
        v1 = -1; v2 = -1; b1 = '0; b2 = '0; nv = 0; busy18 = 1'b1; busy19 = 1'b0;
        @(posedge Clk);
        #1 D = 16'd500;
        for (int n = 1; n <= 60; n++) begin
            @(posedge Clk);
            if (n == 3) #1 D = 16'd42;
            @(negedge Clk);
            if (n == 18) busy18 = Busy;
            if (n == 19) busy19 = Busy;
            if (Valid) begin
                nv++;
                if (v1 < 0) begin v1 = n; b1 = Bcd; end
                else if (v2 < 0) begin v2 = n; b2 = Bcd; end
            end
        end
        check("b2b_valid_cnt", nv, 2);
        check("b2b_first_at", v1, 18);
        check("b2b_first_bcd", b1, 20'h00500);
        check("b2b_idle_gap", busy18, 0);
        check("b2b_reload", busy19, 1);
        check("b2b_second_at", v2, 36);
        check("b2b_second_bcd", b2, 20'h00042);

        convert(16'd1234, 20'h01234, "scan_prep");

        found = 1'b0;
        prev_an = An;
        for (int n = 0; n < 30 && !found; n++) begin
            @(negedge Clk);
            if (An == 5'b11110 && prev_an != 5'b11110) found = 1'b1;
            else prev_an = An;
        end
        check("scan_sync", found, 1);
        for (int j = 0; j < 24; j++) begin
            check($sformatf("scan_an_%0d", j), An, exp_an[(j / 4) % 5]);
            check($sformatf("scan_seg_%0d", j), Seg, exp_seg[(j / 4) % 5]);
            @(negedge Clk);
        end

        // Reset lands on edge 9 after D changes, abandoning the conversion
        @(posedge Clk);
        #1 D = 16'd999;
        repeat (8) @(posedge Clk);
        #1 Rst = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        check("mid_rst_busy", Busy, 0);
        check("mid_rst_valid", Valid, 0);
        check("mid_rst_bcd", Bcd, 20'h00000);
        check("mid_rst_an", An, 5'b11110);
        check("mid_rst_seg", Seg, 7'b1000000);
        Rst = 1'b0;
        watch(30, fv, nv, nb, vb);
        check("post_rst_valid_at", fv, 18);
        check("post_rst_valid_cnt", nv, 1);
        check("post_rst_bcd", vb, 20'h00999);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
